// File: rtl/pc_unit.sv
// pc_unit: program-counter stage feeding the instruction decoder.
// Holds the PC, a base register and a link-register call stack, and applies
// the decoder's control outputs every cycle.
//
// Ports:
//   clk              rising-edge clock
//   rst              synchronous active-high reset
//   pc_rst           soft reset of the whole unit (RST instruction)
//   pc_ld            take a jump this cycle
//   jmp_mode         00 absolute, 01 base-relative, 10 return, 11 as 00
//   jmp_addr         absolute jump target
//   base_reg_offset  offset added to base_reg for base-relative jumps
//   base_reg_ld      load base_reg with base_reg_data
//   base_reg_data    base register load value
//   lr_ld            CALL: push return address (with pc_ld, mode != 10)
//   pc               program memory address
//   base_reg         current base register
//   lr_top           top-of-stack entry, 0 when the stack is empty
//   lr_empty         stack pointer is 0
//   lr_full          stack pointer equals LR_DEPTH
//   stk_err          sticky stack overflow/underflow flag
module pc_unit #(
  parameter int WIDTH    = 8,
  parameter int LR_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pc_rst,
  input  logic             pc_ld,
  input  logic [1:0]       jmp_mode,
  input  logic [WIDTH-1:0] jmp_addr,
  input  logic [WIDTH-1:0] base_reg_offset,
  input  logic             base_reg_ld,
  input  logic [WIDTH-1:0] base_reg_data,
  input  logic             lr_ld,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] base_reg,
  output logic [WIDTH-1:0] lr_top,
  output logic             lr_empty,
  output logic             lr_full,
  output logic             stk_err
);

  localparam int SPW    = $clog2(LR_DEPTH + 1);
  localparam int IDXW   = (LR_DEPTH > 1) ? $clog2(LR_DEPTH) : 1;
  localparam int NSLOTS = 1 << IDXW;
  localparam logic [SPW-1:0] SP_MAX = SPW'(LR_DEPTH);

  logic [WIDTH-1:0] pc_r, base_r, top_r;
  logic [SPW-1:0]   sp_r;
  logic             err_r, empty_r, full_r;
  logic [WIDTH-1:0] stack_r [NSLOTS];

  logic [WIDTH-1:0] pc_inc_s, pc_nx_s, base_nx_s, top_nx_s;
  logic [SPW-1:0]   sp_nx_s;
  logic             err_nx_s, push_s;

  assign pc_inc_s = pc_r + {{(WIDTH-1){1'b0}}, 1'b1};

  // Next-state decode for PC, base register, stack pointer, error flag and
  // the cached top-of-stack value.
  always_comb begin
    pc_nx_s   = pc_inc_s;
    base_nx_s = base_r;
    sp_nx_s   = sp_r;
    err_nx_s  = err_r;
    top_nx_s  = top_r;
    push_s    = 1'b0;
    if (pc_rst) begin
      pc_nx_s   = {WIDTH{1'b0}};
      base_nx_s = {WIDTH{1'b0}};
      sp_nx_s   = {SPW{1'b0}};
      err_nx_s  = 1'b0;
      top_nx_s  = {WIDTH{1'b0}};
    end else begin
      if (base_reg_ld) begin
        base_nx_s = base_reg_data;
      end else begin
        base_nx_s = base_r;
      end
      if (pc_ld) begin
        case (jmp_mode)
          2'b10: begin
            if (sp_r != {SPW{1'b0}}) begin
              pc_nx_s = top_r;
              sp_nx_s = sp_r - SPW'(1);
              // New top is the entry below the one being popped.
              if (sp_r > SPW'(1)) begin
                top_nx_s = stack_r[IDXW'(sp_r - SPW'(2))];
              end else begin
                top_nx_s = {WIDTH{1'b0}};
              end
            end else begin
              pc_nx_s  = pc_inc_s;
              err_nx_s = 1'b1;
            end
          end
          2'b01:   pc_nx_s = base_r + base_reg_offset;
          default: pc_nx_s = jmp_addr;
        endcase
        // A push is only a CALL when the mode is not a return.
        if (lr_ld && (jmp_mode != 2'b10)) begin
          if (sp_r == SP_MAX) begin
            err_nx_s = 1'b1;
          end else begin
            push_s   = 1'b1;
            sp_nx_s  = sp_r + SPW'(1);
            top_nx_s = pc_inc_s;
          end
        end else begin
          push_s = 1'b0;
        end
      end else begin
        pc_nx_s = pc_inc_s;
      end
    end
  end

  // Architectural state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= {WIDTH{1'b0}};
      base_r  <= {WIDTH{1'b0}};
      sp_r    <= {SPW{1'b0}};
      err_r   <= 1'b0;
      top_r   <= {WIDTH{1'b0}};
      empty_r <= 1'b1;
      full_r  <= 1'b0;
    end else begin
      pc_r    <= pc_nx_s;
      base_r  <= base_nx_s;
      sp_r    <= sp_nx_s;
      err_r   <= err_nx_s;
      top_r   <= top_nx_s;
      empty_r <= (sp_nx_s == {SPW{1'b0}});
      full_r  <= (sp_nx_s == SP_MAX);
    end
  end

  // Stack storage; entries are left intact on reset and hidden by sp.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      stack_r[IDXW'(sp_r)] <= pc_inc_s;
    end
  end

  assign pc       = pc_r;
  assign base_reg = base_r;
  assign lr_top   = top_r;
  assign lr_empty = empty_r;
  assign lr_full  = full_r;
  assign stk_err  = err_r;

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter stage directly upstream of the instruction decoder `id`. It holds the PC, base register and a link-register call stack. Each cycle it applies the control outputs that `id` produced for the current instruction (`pc_rst`, `pc_ld`, `jmp_mode`, `lr_ld`, `base_reg_*`). Its `pc` output addresses program memory, and program memory returns the next `instr`/`arg` pair to `id`.

## Interface
Parameters:
- `WIDTH`, 8, width of PC, base register, offsets and stack entries
- `LR_DEPTH`, 4, link stack depth in entries (≥1)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `pc_rst`  in  1  RST instruction from `id`; soft reset of the whole unit
- `pc_ld`  in  1  take jump this cycle; the Z condition is already resolved by `id`
- `jmp_mode`  in  2  00 absolute, 01 base-relative, 10 return, 11 reserved (treated as 00)
- `jmp_addr`  in  WIDTH  absolute target (from `id` `imm`)
- `base_reg_offset`  in  WIDTH  offset for base-relative jump
- `base_reg_ld`  in  1  load base register
- `base_reg_data`  in  WIDTH  base register load value
- `lr_ld`  in  1  CALL: push return address; only honoured with `pc_ld`=1 and `jmp_mode`≠10
- `pc`  out  WIDTH  program memory address
- `base_reg`  out  WIDTH  current base register
- `lr_top`  out  WIDTH  top-of-stack entry; 0 when empty
- `lr_empty`  out  1  stack pointer == 0
- `lr_full`  out  1  stack pointer == `LR_DEPTH`
- `stk_err`  out  1  sticky overflow/underflow flag

## Operation
- State: `pc`, `base_reg`, stack array [`LR_DEPTH`], stack pointer `sp` (0..`LR_DEPTH`), `stk_err`. All outputs are driven from registered state; there is no combinational path from inputs to outputs.
- Priority per cycle: `rst` > `pc_rst` > `pc_ld` > increment.
- `rst` or `pc_rst`: `pc`=0, `base_reg`=0, `sp`=0, `stk_err`=0. All other inputs are ignored that cycle, including `base_reg_ld`.
- Next PC when `pc_ld`=0: `pc+1`.
- Next PC when `pc_ld`=1:
  - 00/11: `jmp_addr`.
  - 01: `base_reg + base_reg_offset`, using the pre-edge `base_reg`.
  - 10: stack top, then pop (`sp`−1).
- Arithmetic: all sums are modulo 2^WIDTH. 0xFF+1 → 0x00. Base 0xF0 + offset 0x20 → 0x10.
- CALL (`pc_ld`=1, `lr_ld`=1, mode 00/01/11):
  - Push `pc+1` (mod 2^WIDTH), then jump per mode.
  - Stack full: no push, `stk_err`←1, jump still taken.
- Return with stack empty: no jump, `pc`←`pc+1`, `stk_err`←1.
- `lr_ld` with mode 10: push is ignored; a return is performed.
- `lr_ld` with `pc_ld`=0: ignored.
- `base_reg_ld`: `base_reg`←`base_reg_data`. This happens in parallel with any PC action except reset.
- `stk_err` is cleared only by `rst`/`pc_rst`.
- `lr_top` = stack[`sp`−1] when `sp`>0, else 0. Stack entries are not cleared on reset, but are never visible while `sp`=0.

## Timing
- Single-cycle stage. Inputs sampled at edge N; new `pc`/`base_reg`/stack outputs are valid after edge N.
- `id` decodes the instruction at `pc`, and its outputs are sampled at the next edge, so a jump takes effect one cycle after the jump instruction is presented. There are no delay slots.
- Reset values: `pc`=0, `base_reg`=0, `lr_top`=0, `lr_empty`=1, `lr_full`=0, `stk_err`=0.
- Reset in the middle of a call sequence discards all stack contents; the first instruction after reset is fetched from address 0.
- `rst` asserted for multiple cycles holds all state at reset values.

## Test plan
- Reset/increment: assert `rst` 1 cycle, then idle 4 cycles → `pc`=0,1,2,3,4; `lr_empty`=1, `stk_err`=0. Preload `pc`=0xFF, then idle → wraps to 0x00.
- Absolute and base-relative:
  - `pc_ld`=1, mode 00, `jmp_addr`=0x2B → `pc`=0x2B.
  - `base_reg_ld` with 0xA1 → `base_reg`=0xA1.
  - Mode 01, offset 0x0C → `pc`=0xAD.
  - Mode 01, offset 0x70 → `pc`=0x11 (wrap).
- Same-cycle base load and relative jump: `base_reg`=0x10; in one cycle `base_reg_ld`=1 with data 0x50, plus mode 01 with offset 0x02 → `pc`=0x12 and `base_reg`=0x50 afterwards.
- CALL/RET nesting:
  - At `pc`=0x05, CALL 0x06 → `pc`=0x06, `lr_top`=0x06.
  - At 0x08, CALL 0x40 → `lr_top`=0x09.
  - RET → `pc`=0x09. RET → `pc`=0x06, `lr_empty`=1.
- Overflow/underflow:
  - 5 CALLs with `LR_DEPTH`=4 → `lr_full`=1 after the 4th; 5th jumps but `stk_err`=1 and `sp` stays 4.
  - From empty, RET at `pc`=0x30 → `pc`=0x31, `stk_err`=1.
- Soft reset mid-operation: with `sp`=2, `base_reg`=0x33, `stk_err`=1, assert `pc_rst` together with `pc_ld` and `base_reg_ld` → all state returns to reset values; `pc_ld`/`base_reg_ld` have no effect.
